px_stream_scheduler: RTL
========================

PX_STREAM_SCHEDULER -- requirements
Module: px_stream_scheduler

Interface
REQ-001 Parameter PX_BITS, default 24, SHALL set the pixel width.
REQ-002 Parameter FRAME_PX, default 64, SHALL set the pixels per frame (legal range 1..65535).
REQ-003 Parameter GAP_CYCLES, default 2, SHALL set the idle cycles between pixels issued to the core (legal range 0..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- mode_i  in  2  source select: 00 = requester 0 only (SPI), 01 = requester 1 only (LFSR), 10 = round-robin between both, 11 = reserved and treated as 00.
- start_i  in  1  single-cycle pulse that starts a frame.
- req0_vld_i  in  1  requester 0 pixel strobe.
- req0_px_i  in  PX_BITS  requester 0 pixel.
- req0_busy_o  out  1  requester 0 holding register is full.
- req1_vld_i  in  1  requester 1 pixel strobe.
- req1_px_i  in  PX_BITS  requester 1 pixel.
- req1_busy_o  out  1  requester 1 holding register is full.
- core_px_o  out  PX_BITS  pixel driven to the gray/sobel core.
- core_px_rdy_o  out  1  single-cycle pixel-valid strobe to the core.
- core_start_o  out  1  core enable; high while a frame is active.
- grant_o  out  2  one-hot indication of the requester currently being issued.
- px_count_o  out  16  number of pixels issued in the current frame.
- frame_done_o  out  1  single-cycle end-of-frame pulse.
- ovf_o  out  2  sticky overflow flags, bit n for requester n.

Function
REQ-005 Each requester SHALL have a one-entry holding register; a full flag SHALL be set when vld is high, the register is empty and the requester is enabled by the latched mode.
- reqN_busy_o SHALL equal the full flag as registered.
REQ-006 A vld on an enabled requester whose register is full SHALL drop the data and set ovf_o[N]; a vld on a disabled requester SHALL be ignored with no flag.
REQ-007 The FSM SHALL have exactly five states: IDLE, ARB, ISSUE, GAP, DONE.
REQ-008 IDLE: on start_i the block SHALL latch mode_i, clear px_count_o, and go to ARB; start_i and mode_i changes outside IDLE SHALL be ignored.
REQ-009 core_start_o SHALL be high in ARB, ISSUE, GAP and DONE, and low in IDLE.
REQ-010 ARB: the block SHALL wait until an enabled holding register is full, then select a requester and go to ISSUE.
- In round-robin mode with both registers full, it SHALL pick the requester indicated by the round-robin pointer.
- The pointer SHALL toggle after every grant made in round-robin mode.
- The pointer SHALL reset to requester 0.
REQ-011 ISSUE: for exactly one cycle the block SHALL drive core_px_rdy_o=1 and core_px_o = the granted register's data.
- grant_o SHALL be one-hot for the granted requester.
- The granted register's full flag SHALL be cleared at the end of the cycle.
- px_count_o SHALL increment at the end of the cycle.
REQ-012 A vld on the granted requester during its ISSUE cycle SHALL be dropped with ovf set, because busy_o is still high.
REQ-013 After ISSUE, the block SHALL go to DONE if the new count equals FRAME_PX; otherwise it SHALL go to GAP, or directly to ARB when GAP_CYCLES=0.
REQ-014 GAP SHALL last exactly GAP_CYCLES cycles, then go to ARB; pixel latency from a full register to core_px_rdy_o SHALL be 2 cycles minimum (ARB, then ISSUE).
REQ-015 DONE SHALL assert frame_done_o for one cycle and then go to IDLE.
- px_count_o SHALL hold its final value until the next start_i.
- Holding-register contents SHALL be retained across frames.
REQ-016 Outside ISSUE, core_px_rdy_o=0, grant_o=00, and core_px_o SHALL hold its last issued value.
REQ-017 ovf_o SHALL clear only on reset or on an accepted start_i.

Reset
REQ-018 While reset_i=1, independent of clk_i, the block SHALL hold:
- the FSM in IDLE;
- both full flags, ovf_o and the round-robin pointer at 0;
- core_px_o=0, core_px_rdy_o=0, core_start_o=0, grant_o=00, px_count_o=0, frame_done_o=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no frame_done_o pulse; after release, the block SHALL respond only to a new start_i.

Verification
REQ-020 Reset, mode=00, FRAME_PX=4, GAP=2, start, then four req0 pixels 0x000011..0x000044 spaced 5 cycles apart -> four core_px_rdy_o pulses in order, each 2 cycles after its vld, grant_o=01 each time, frame_done_o pulses once, and px_count_o=4.
REQ-021 Mode=10 with req0 and req1 both holding data at ARB -> requester 0 is issued first, then requester 1; grant_o sequence is 01, 10.
REQ-022 Mode=01 with req0_vld_i pulsed -> no issue and ovf_o=00; a req1 pixel 0xABCDEF -> core_px_o=0xABCDEF.
REQ-023 Two req0 vld pulses on consecutive cycles while the FSM is in GAP -> first captured, second dropped, ovf_o=01 until the next start_i.
REQ-024 reset_i asserted on the ISSUE cycle of pixel 2 -> all outputs return to their reset values asynchronously, no frame_done_o pulse; a new frame after release delivers pixels starting from px_count_o=0.
REQ-025 GAP_CYCLES=0 with both registers kept full in mode 10 -> core_px_rdy_o pulses every 2 cycles, alternating grants, and the frame ends when px_count_o=FRAME_PX.

Source files
------------

// File: rtl/px_stream_scheduler.sv
// px_stream_scheduler: arbitrates two one-entry pixel requesters into a paced per-frame pixel stream for the core
module px_stream_scheduler #(
  parameter int PX_BITS    = 24,
  parameter int FRAME_PX   = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         mode_i,
  input  logic               start_i,
  input  logic               req0_vld_i,
  input  logic [PX_BITS-1:0] req0_px_i,
  output logic               req0_busy_o,
  input  logic               req1_vld_i,
  input  logic [PX_BITS-1:0] req1_px_i,
  output logic               req1_busy_o,
  output logic [PX_BITS-1:0] core_px_o,
  output logic               core_px_rdy_o,
  output logic               core_start_o,
  output logic [1:0]         grant_o,
  output logic [15:0]        px_count_o,
  output logic               frame_done_o,
  output logic [1:0]         ovf_o
);
  typedef enum logic [2:0] {IDLE, ARB, ISSUE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d, full_q, full_d, ovf_q, ovf_d;
  logic [1:0] en, vld, acc, cand, clr;
  logic ptr_q, ptr_d, gsel_q, gsel_d, pick, issue, start_acc;
  logic [PX_BITS-1:0] hold0_q, hold0_d, hold1_q, hold1_d, px_q, px_d;
  logic [15:0] cnt_q, cnt_d, cnt_n;
  logic [3:0] gap_q, gap_d;
  assign en        = {mode_q == 2'b01 || mode_q == 2'b10, mode_q != 2'b01};
  assign vld       = {req1_vld_i, req0_vld_i};
  assign acc       = vld & en & ~full_q;
  assign cand      = full_q & en;
  assign pick      = (&cand) ? ptr_q : cand[1];
  assign issue     = state_q == ISSUE;
  assign start_acc = state_q == IDLE && start_i;
  assign clr       = issue ? (gsel_q ? 2'b10 : 2'b01) : 2'b00;
  assign cnt_n     = cnt_q + 16'd1;
  // Holding registers: capture into an empty enabled slot, drop and flag overflow when full
  always_comb begin
    full_d  = (full_q & ~clr) | acc;
    ovf_d   = (start_acc ? 2'b00 : ovf_q) | (vld & en & full_q);
    hold0_d = acc[0] ? req0_px_i : hold0_q;
    hold1_d = acc[1] ? req1_px_i : hold1_q;
  end
  // Frame sequencing: arbitrate, issue one pixel, pace with gap cycles, end at FRAME_PX
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    gsel_d  = gsel_q;
    px_d    = px_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (start_i) begin
        mode_d  = mode_i;
        cnt_d   = '0;
        state_d = ARB;
      end
      ARB: if (|cand) begin
        gsel_d  = pick;
        px_d    = pick ? hold1_q : hold0_q;
        ptr_d   = ptr_q ^ (mode_q == 2'b10);
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = cnt_n;
        gap_d   = '0;
        state_d = (cnt_n == 16'(FRAME_PX)) ? DONE : (GAP_CYCLES == 0) ? ARB : GAP;
      end
      GAP: begin
        gap_d   = gap_q + 4'd1;
        state_d = (gap_q == 4'(GAP_CYCLES - 1)) ? ARB : GAP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mode_q  <= '0;
      full_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= 1'b0;
      gsel_q  <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
      px_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      gsel_q  <= gsel_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      px_q    <= px_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end
  assign req0_busy_o   = full_q[0];
  assign req1_busy_o   = full_q[1];
  assign core_px_o     = px_q;
  assign core_px_rdy_o = issue;
  assign core_start_o  = state_q != IDLE;
  assign grant_o       = clr;
  assign px_count_o    = cnt_q;
  assign frame_done_o  = state_q == DONE;
  assign ovf_o         = ovf_q;
endmodule
